data_mem_sys: RTL and testbench

Data-side memory subsystem attached directly to the CPU core's data port (`ram_ce`/`ram_we`/`ram_sel`/`ram_addr`/`ram_data_o` in, `ram_data` back). It consumes the loads and stores produced by the MEM stage. It provides:
- a byte-writable word RAM;
- a memory-mapped 32-bit timer with compare flag and interrupt;
- a small byte TX FIFO drained through a valid/ready handshake.

Reads are combinational so the MEM stage completes in one cycle without stalling. Writes commit on the clock edge.

---
 rtl/data_mem_sys.sv | 148 ++++++++++++++
 tb/tb_data_mem_sys.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_sys.sv
// Data-side memory subsystem: byte-writable word RAM, free-running timer with
// compare/irq, and a byte TX FIFO drained over valid/ready. Reads are combinational.
module data_mem_sys #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [31:0] A_CNT = 32'h1000_0000;
  localparam logic [31:0] A_CMP = 32'h1000_0004;
  localparam logic [31:0] A_STS = 32'h1000_0008;
  localparam logic [31:0] A_TX  = 32'h1000_000C;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [3:0] lanes,
                                        input logic [31:0] new_v);
    logic [31:0] m;
    m = old_v;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) m[8*b +: 8] = new_v[8*b +: 8];
    end
    return m;
  endfunction

  logic [31:0] mem_q [RAM_WORDS];
  logic [31:0] mem_wdata;
  logic [31:0] cnt_q, cnt_d, cmp_q, cmp_d;
  logic        match_q, match_d, ovf_q, ovf_d;
  logic [7:0]  fifo_q [FIFO_DEPTH];
  logic [7:0]  fifo_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic wr_en, rd_en;
  logic hit_ram, hit_cnt, hit_cmp, hit_sts, hit_tx;
  logic [AW-1:0] ram_idx;
  logic full, empty, pop, push, push_req;
  logic [31:0] status;

  assign wr_en   = ce & we;
  assign rd_en   = ce & ~we;
  assign hit_ram = addr < RAM_BYTES;
  assign hit_cnt = addr[31:2] == A_CNT[31:2];
  assign hit_cmp = addr[31:2] == A_CMP[31:2];
  assign hit_sts = addr[31:2] == A_STS[31:2];
  assign hit_tx  = addr[31:2] == A_TX[31:2];
  assign ram_idx = addr[AW+1:2];

  assign full     = count_q == CW'(FIFO_DEPTH);
  assign empty    = count_q == '0;
  assign pop      = ~empty & tx_ready;
  assign push_req = wr_en & hit_tx & sel[0];
  // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
  assign push     = push_req & (~full | pop);

  assign tx_valid = ~empty;
  assign tx_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign irq      = match_q;

  always_comb begin
    status        = '0;
    status[0]     = match_q;
    status[1]     = full;
    status[2]     = empty;
    status[3]     = ovf_q;
    status[11:4]  = 8'(count_q);
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      if (hit_ram)      rdata = mem_q[ram_idx];
      else if (hit_cnt) rdata = cnt_q;
      else if (hit_cmp) rdata = cmp_q;
      else if (hit_sts) rdata = status;
    end
  end

  always_comb begin
    mem_wdata = merge(mem_q[ram_idx], sel, wdata);
    cnt_d     = cnt_q + 32'd1;
    cmp_d     = cmp_q;
    if (wr_en && hit_cnt) cnt_d = merge(cnt_q, sel, wdata);
    if (wr_en && hit_cmp) cmp_d = merge(cmp_q, sel, wdata);
    // Set terms are OR-ed last so they win over a same-edge clear.
    match_d = (match_q & ~(wr_en & hit_sts & sel[0] & wdata[0])) | (cnt_q == cmp_q);
    ovf_d   = (ovf_q & ~(wr_en & hit_sts & sel[0] & wdata[3])) | (push_req & ~push);
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = wdata[7:0];
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en && hit_ram) mem_q[ram_idx] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      cmp_q    <= 32'hFFFF_FFFF;
      match_q  <= 1'b0;
      ovf_q    <= 1'b0;
      fifo_q   <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      cmp_q    <= cmp_d;
      match_q  <= match_d;
      ovf_q    <= ovf_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_data_mem_sys.sv
// Directed self-checking bench for data_mem_sys: RAM lanes, timer, compare/irq,
// TX FIFO fill/drain/overflow and asynchronous reset.
module tb_data_mem_sys;

  localparam logic [31:0] A_CNT = 32'h1000_0000;
  localparam logic [31:0] A_CMP = 32'h1000_0004;
  localparam logic [31:0] A_STS = 32'h1000_0008;
  localparam logic [31:0] A_TX  = 32'h1000_000C;

  logic        clk, rst, ce, we, tx_ready, tx_valid, irq;
  logic [3:0]  sel;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  tx_data;

  int n_cmp = 0;
  int n_mis = 0;

  data_mem_sys dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .sel(sel), .addr(addr),
    .wdata(wdata), .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ce = 1'b0; we = 1'b0; sel = 4'h0; addr = '0; wdata = '0;
  endtask

  // Called at a negedge; the write commits on the following posedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    ce = 1'b1; we = 1'b1; sel = s; addr = a; wdata = d;
    @(negedge clk);
    idle();
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    ce = 1'b1; we = 1'b0; sel = 4'hF; addr = a;
    #1;
    chk(tag, rdata, exp);
    idle();
  endtask

  logic [7:0] drain_exp [4];

  initial begin
    rst = 1'b1; tx_ready = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    #1 chk("rst_rdata_idle", rdata, 32'd0);
    rst = 1'b0;
    rd_chk("cnt_first", A_CNT, 32'd0);
    rd_chk("cmp_rst", A_CMP, 32'hFFFF_FFFF);
    rd_chk("sts_rst", A_STS, 32'h4);
    repeat (10) @(negedge clk);
    rd_chk("cnt_10", A_CNT, 32'd10);

    // RAM byte lanes and decode
    wr(32'h40, 32'hAABB_CCDD, 4'hF);
    wr(32'h40, 32'h1122_3344, 4'h5);
    rd_chk("ram_lanes", 32'h40, 32'hAA22_CC44);
    wr(32'h40, 32'h5555_5555, 4'h0);
    rd_chk("ram_sel0", 32'h40, 32'hAA22_CC44);
    rd_chk("unmapped", 32'h2000_0000, 32'd0);
    rd_chk("tx_rd_zero", A_TX, 32'd0);
    wr(32'h0, 32'h0, 4'hF);
    wr(32'hFFC, 32'hCAFE_F00D, 4'hF);
    wr(32'h1000, 32'hFFFF_FFFF, 4'hF);
    rd_chk("ram_last", 32'hFFC, 32'hCAFE_F00D);
    rd_chk("ram_noalias", 32'h0, 32'd0);
    rd_chk("ram_oob_rd", 32'h1000, 32'd0);
    ce = 1'b1; we = 1'b1; addr = 32'h40; #1;
    chk("rdata_on_write", rdata, 32'd0);
    idle();

    // Timer wrap; CMP is still all-ones so wrapping also raises match
    chk("irq_pre_wrap", 32'(irq), 32'd0);
    wr(A_CNT, 32'hFFFF_FFFE, 4'hF);
    rd_chk("cnt_load", A_CNT, 32'hFFFF_FFFE);
    @(negedge clk);
    rd_chk("cnt_max", A_CNT, 32'hFFFF_FFFF);
    chk("irq_before_max_match", 32'(irq), 32'd0);
    @(negedge clk);
    rd_chk("cnt_wrap", A_CNT, 32'd0);
    chk("irq_max_match", 32'(irq), 32'd1);
    wr(A_STS, 32'h1, 4'h1);
    chk("irq_clr1", 32'(irq), 32'd0);
    wr(A_CNT, 32'h0000_0100, 4'hF);
    wr(A_CNT, 32'h0000_AB00, 4'h2);
    rd_chk("cnt_lane", A_CNT, 32'h0000_AB00);

    // Compare / irq
    wr(A_CMP, 32'd20, 4'hF);
    wr(A_CNT, 32'd0, 4'hF);
    repeat (20) @(negedge clk);
    rd_chk("cnt_20", A_CNT, 32'd20);
    chk("irq_at_eq", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_after_eq", 32'(irq), 32'd1);
    rd_chk("sts_match", A_STS, 32'h5);
    wr(A_STS, 32'h0, 4'h1);
    chk("irq_w0_keeps", 32'(irq), 32'd1);
    wr(A_STS, 32'h1, 4'h1);
    chk("irq_clr2", 32'(irq), 32'd0);
    wr(A_CNT, 32'd100, 4'hF);
    wr(A_CMP, 32'd102, 4'hF);
    @(negedge clk);
    rd_chk("cnt_102", A_CNT, 32'd102);
    chk("irq_pre_race", 32'(irq), 32'd0);
    wr(A_STS, 32'h1, 4'h1);
    chk("irq_set_wins", 32'(irq), 32'd1);
    wr(A_STS, 32'h1, 4'h1);
    chk("irq_clr3", 32'(irq), 32'd0);

    // FIFO fill / overflow / drain
    wr(A_TX, 32'h99, 4'hE);
    chk("tx_sel0_ignored", 32'(tx_valid), 32'd0);
    wr(A_TX, 32'h41, 4'h1);
    chk("tx_valid_push", 32'(tx_valid), 32'd1);
    chk("tx_head_41", 32'(tx_data), 32'h41);
    wr(A_TX, 32'h42, 4'h1);
    wr(A_TX, 32'h43, 4'h1);
    wr(A_TX, 32'h44, 4'h1);
    rd_chk("sts_full", A_STS, 32'h42);
    wr(A_TX, 32'h45, 4'h1);
    rd_chk("sts_ovf", A_STS, 32'h4A);
    chk("tx_hold", 32'(tx_data), 32'h41);
    drain_exp = '{8'h41, 8'h42, 8'h43, 8'h44};
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("drain1_%0d", i), 32'(tx_data), 32'(drain_exp[i]));
      @(negedge clk);
    end
    chk("drain1_valid0", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    rd_chk("sts_empty_ovf", A_STS, 32'hC);
    wr(A_STS, 32'h8, 4'h1);
    rd_chk("sts_ovf_clr", A_STS, 32'h4);

    // Full FIFO with simultaneous push and pop
    wr(A_TX, 32'h51, 4'h1);
    wr(A_TX, 32'h52, 4'h1);
    wr(A_TX, 32'h53, 4'h1);
    wr(A_TX, 32'h54, 4'h1);
    tx_ready = 1'b1;
    wr(A_TX, 32'h55, 4'h1);
    tx_ready = 1'b0;
    rd_chk("sts_pushpop", A_STS, 32'h42);
    drain_exp = '{8'h52, 8'h53, 8'h54, 8'h55};
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("drain2_%0d", i), 32'(tx_data), 32'(drain_exp[i]));
      @(negedge clk);
    end
    chk("drain2_valid0", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    // Asynchronous reset mid-fill
    wr(A_TX, 32'h61, 4'h1);
    wr(A_TX, 32'h62, 4'h1);
    wr(A_TX, 32'h63, 4'h1);
    rd_chk("sts_cnt3", A_STS, 32'h30);
    #3 rst = 1'b1;
    #1 chk("arst_tx_valid", 32'(tx_valid), 32'd0);
    rd_chk("arst_sts", A_STS, 32'h4);
    rd_chk("arst_cnt", A_CNT, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("arst_cmp", A_CMP, 32'hFFFF_FFFF);
    rd_chk("post_rst_cnt0", A_CNT, 32'd0);
    @(negedge clk);
    rd_chk("post_rst_cnt1", A_CNT, 32'd1);
    chk("post_rst_irq", 32'(irq), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
